axi_eth_tx_arb: RTL and testbench

Ethernet transmit scheduler sharing a single 8-bit MAC TX AXI-Stream between the ARP and IPv4 transmit engines. Arbitration is round-robin and happens at frame granularity. Once a requester is granted, the block emits the 14-byte Ethernet header (destination MAC from the requester, source MAC from parameters, fixed ethertype per port), then forwards that requester's payload until `tlast`. It is the transmit-side counterpart of the receive demultiplexer and sits between the protocol engines and the MAC.

---
 rtl/axi_eth_tx_arb.sv | 118 +++++++++++
 tb/tb_axi_eth_tx_arb.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_eth_tx_arb.sv
// axi_eth_tx_arb: round-robin ARP/IPv4 frame scheduler onto one MAC TX stream with header insertion.
// Define AXI_ETH_TX_PAD_EN to pad short frames to 60 bytes.
module axi_eth_tx_arb #(
   parameter logic [23:0] MAC_MSB = 24'h010203,
   parameter logic [23:0] MAC_LSB = 24'h040506
) (
   input  logic        clk,
   input  logic        aresetn,
   input  logic [7:0]  arp_axis_tdata,
   input  logic        arp_axis_tvalid,
   input  logic        arp_axis_tlast,
   output logic        arp_axis_tready,
   input  logic [47:0] arp_dst_mac,
   input  logic [7:0]  ip_axis_tdata,
   input  logic        ip_axis_tvalid,
   input  logic        ip_axis_tlast,
   output logic        ip_axis_tready,
   input  logic [47:0] ip_dst_mac,
   output logic [7:0]  mac_axis_tdata,
   output logic        mac_axis_tvalid,
   output logic        mac_axis_tlast,
   input  logic        mac_axis_tready,
   output logic        busy,
   output logic [1:0]  grant
);
`ifdef AXI_ETH_TX_PAD_EN
   typedef enum logic [1:0] {S_IDLE, S_HEADER, S_PAYLOAD, S_PAD} state_t;
   logic [10:0] byte_cnt;
`else
   typedef enum logic [1:0] {S_IDLE, S_HEADER, S_PAYLOAD} state_t;
`endif
   state_t state, state_nxt;
   logic [47:0] dst_mac;
   logic [15:0] ethertype;
   logic [3:0] hdr_idx;
   logic [111:0] hdr_sh;
   logic last_ip, req, pick_ip, sel_ip, acc;
   logic [7:0] src_data;
   logic src_valid, src_last;
   assign hdr_sh = {dst_mac, MAC_MSB, MAC_LSB, ethertype} << {hdr_idx, 3'b000};
   assign req = arp_axis_tvalid | ip_axis_tvalid;
   // On a tie the port that did not win last time is served
   assign pick_ip = ip_axis_tvalid & (~arp_axis_tvalid | ~last_ip);
   assign sel_ip = grant[1];
   assign src_data = sel_ip ? ip_axis_tdata : arp_axis_tdata;
   assign src_valid = sel_ip ? ip_axis_tvalid : arp_axis_tvalid;
   assign src_last = sel_ip ? ip_axis_tlast : arp_axis_tlast;
   assign acc = mac_axis_tvalid & mac_axis_tready;
   assign busy = state != S_IDLE;
   always_comb begin
      state_nxt = state;
      mac_axis_tvalid = 1'b0;
      mac_axis_tlast = 1'b0;
      mac_axis_tdata = 8'h00;
      arp_axis_tready = 1'b0;
      ip_axis_tready = 1'b0;
      case (state)
         S_IDLE: state_nxt = req ? S_HEADER : S_IDLE;
         S_HEADER: begin
            mac_axis_tvalid = 1'b1;
            mac_axis_tdata = hdr_sh[111:104];
            state_nxt = (mac_axis_tready && hdr_idx == 4'd13) ? S_PAYLOAD : S_HEADER;
         end
         S_PAYLOAD: begin
            mac_axis_tvalid = src_valid;
            mac_axis_tdata = src_data;
            mac_axis_tlast = src_last;
            arp_axis_tready = ~sel_ip & mac_axis_tready;
            ip_axis_tready = sel_ip & mac_axis_tready;
            state_nxt = (src_valid && mac_axis_tready && src_last) ? S_IDLE : S_PAYLOAD;
`ifdef AXI_ETH_TX_PAD_EN
            if (src_valid && mac_axis_tready && src_last && byte_cnt < 11'd59) begin
               mac_axis_tlast = 1'b0;
               state_nxt = S_PAD;
            end
`endif
         end
`ifdef AXI_ETH_TX_PAD_EN
         S_PAD: begin
            mac_axis_tvalid = 1'b1;
            mac_axis_tlast = byte_cnt == 11'd59;
            state_nxt = (mac_axis_tready && byte_cnt == 11'd59) ? S_IDLE : S_PAD;
         end
`endif
         default: state_nxt = S_IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (!aresetn) state <= S_IDLE;
      else state <= state_nxt;
   end
   always_ff @(posedge clk) begin
      if (!aresetn) begin
         grant <= 2'b00;
         last_ip <= 1'b1;
         hdr_idx <= 4'd0;
         dst_mac <= 48'h0;
         ethertype <= 16'h0;
`ifdef AXI_ETH_TX_PAD_EN
         byte_cnt <= 11'd0;
`endif
      end else begin
         if (state == S_IDLE && req) begin
            grant <= pick_ip ? 2'b10 : 2'b01;
            last_ip <= pick_ip;
            dst_mac <= pick_ip ? ip_dst_mac : arp_dst_mac;
            ethertype <= pick_ip ? 16'h0800 : 16'h0806;
            hdr_idx <= 4'd0;
         end
         if (state == S_HEADER && acc) hdr_idx <= hdr_idx + 4'd1;
         if (state != S_IDLE && state_nxt == S_IDLE) grant <= 2'b00;
`ifdef AXI_ETH_TX_PAD_EN
         if (state == S_IDLE && req) byte_cnt <= 11'd0;
         else if (acc && byte_cnt != 11'h7ff) byte_cnt <= byte_cnt + 11'd1;
`endif
      end
   end
endmodule

// File: tb/tb_axi_eth_tx_arb.sv
// tb_axi_eth_tx_arb: random payloads checked against a frame-level round-robin/header model.
module tb_axi_eth_tx_arb;
`ifdef AXI_ETH_TX_PAD_EN
   localparam bit PAD = 1'b1;
`else
   localparam bit PAD = 1'b0;
`endif
   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic aresetn;
   logic [7:0] arp_axis_tdata, ip_axis_tdata, mac_axis_tdata;
   logic arp_axis_tvalid, arp_axis_tlast, arp_axis_tready;
   logic ip_axis_tvalid, ip_axis_tlast, ip_axis_tready;
   logic [47:0] arp_dst_mac, ip_dst_mac;
   logic mac_axis_tvalid, mac_axis_tlast, mac_axis_tready, busy;
   logic [1:0] grant;
   axi_eth_tx_arb dut (
      .clk(clk), .aresetn(aresetn),
      .arp_axis_tdata(arp_axis_tdata), .arp_axis_tvalid(arp_axis_tvalid),
      .arp_axis_tlast(arp_axis_tlast), .arp_axis_tready(arp_axis_tready), .arp_dst_mac(arp_dst_mac),
      .ip_axis_tdata(ip_axis_tdata), .ip_axis_tvalid(ip_axis_tvalid),
      .ip_axis_tlast(ip_axis_tlast), .ip_axis_tready(ip_axis_tready), .ip_dst_mac(ip_dst_mac),
      .mac_axis_tdata(mac_axis_tdata), .mac_axis_tvalid(mac_axis_tvalid),
      .mac_axis_tlast(mac_axis_tlast), .mac_axis_tready(mac_axis_tready),
      .busy(busy), .grant(grant)
   );
   int checks = 0, errors = 0;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;
   logic [8:0] arp_q[$], ip_q[$], mq_arp[$], mq_ip[$], cap[$], expq[$];
   int cap_cyc[$];
   logic [1:0] gq[$], egq[$];
   bit model_last_ip, in_frame, tgl, stall_prev;
   logic [8:0] stall_data;
   int rdy_mode, stall_err, req_cyc;

   task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic drive();
      arp_axis_tvalid = arp_q.size() != 0;
      {arp_axis_tlast, arp_axis_tdata} = arp_q.size() != 0 ? arp_q[0] : 9'h0;
      ip_axis_tvalid = ip_q.size() != 0;
      {ip_axis_tlast, ip_axis_tdata} = ip_q.size() != 0 ? ip_q[0] : 9'h0;
      tgl = ~tgl;
      mac_axis_tready = rdy_mode == 0 ? 1'b1 : rdy_mode == 1 ? tgl : 1'($urandom_range(0, 1));
   endtask

   task automatic cycle();
      @(negedge clk);
      if (stall_prev && (!mac_axis_tvalid || {mac_axis_tlast, mac_axis_tdata} !== stall_data)) stall_err++;
      stall_prev = mac_axis_tvalid && !mac_axis_tready;
      stall_data = {mac_axis_tlast, mac_axis_tdata};
      if (mac_axis_tvalid && mac_axis_tready) begin
         if (!in_frame) gq.push_back(grant);
         in_frame = !mac_axis_tlast;
         cap.push_back({mac_axis_tlast, mac_axis_tdata});
         cap_cyc.push_back(cyc);
      end
      if (arp_axis_tvalid && arp_axis_tready) void'(arp_q.pop_front());
      if (ip_axis_tvalid && ip_axis_tready) void'(ip_q.pop_front());
      @(posedge clk);
      #1;
      drive();
   endtask

   task automatic clear_all();
      arp_q.delete(); ip_q.delete(); mq_arp.delete(); mq_ip.delete();
      cap.delete(); cap_cyc.delete(); expq.delete(); gq.delete(); egq.delete();
      in_frame = 1'b0; stall_prev = 1'b0; stall_err = 0;
   endtask

   task automatic do_reset();
      aresetn = 1'b0;
      clear_all();
      drive();
      repeat (2) @(posedge clk);
      #1;
      aresetn = 1'b1;
      model_last_ip = 1'b1;
   endtask

   task automatic add_frame(bit ip, int len);
      logic [8:0] b;
      for (int i = 0; i < len; i++) begin
         b = {i == len - 1, 8'($urandom)};
         if (ip) begin ip_q.push_back(b); mq_ip.push_back(b); end
         else begin arp_q.push_back(b); mq_arp.push_back(b); end
      end
   endtask

   // Whole expected MAC stream: frame order from the round-robin rule, each frame = header + payload (+ pad)
   task automatic build_expected();
      int na = 0, ni = 0, n;
      bit pick, last;
      logic [47:0] mac;
      logic [47:0] src = {24'h010203, 24'h040506};
      logic [8:0] b;
      foreach (mq_arp[i]) na += int'(mq_arp[i][8]);
      foreach (mq_ip[i]) ni += int'(mq_ip[i][8]);
      while (na + ni > 0) begin
         pick = ni > 0 && (na == 0 || !model_last_ip);
         model_last_ip = pick;
         if (pick) ni--; else na--;
         egq.push_back(pick ? 2'b10 : 2'b01);
         mac = pick ? ip_dst_mac : arp_dst_mac;
         for (int i = 0; i < 6; i++) expq.push_back({1'b0, mac[47 - 8 * i -: 8]});
         for (int i = 0; i < 6; i++) expq.push_back({1'b0, src[47 - 8 * i -: 8]});
         expq.push_back(9'h008);
         expq.push_back(pick ? 9'h000 : 9'h006);
         n = 14;
         do begin
            b = pick ? mq_ip.pop_front() : mq_arp.pop_front();
            last = b[8];
            n++;
            if (PAD && last && n < 60) b[8] = 1'b0;
            expq.push_back(b);
         end while (!last);
         while (PAD && n < 60) begin
            n++;
            expq.push_back({n == 60, 8'h00});
         end
      end
   endtask

   task automatic check_stream(string tag);
      int bad = 0, gbad = 0;
      for (int k = 0; k < 20000 && cap.size() < expq.size(); k++) cycle();
      repeat (4) cycle();
      chk({tag, "_len"}, cap.size(), expq.size());
      for (int i = 0; i < cap.size() && i < expq.size(); i++) if (cap[i] !== expq[i]) bad++;
      chk({tag, "_bytes"}, bad, 0);
      for (int i = 0; i < gq.size() && i < egq.size(); i++) if (gq[i] !== egq[i]) gbad++;
      chk({tag, "_grants"}, {gq.size(), gbad}, {egq.size(), 32'd0});
   endtask

   initial begin
      rdy_mode = 0;
      tgl = 1'b0;
      arp_dst_mac = 48'h0;
      ip_dst_mac = 48'h0;
      aresetn = 1'b0;
      clear_all();
      drive();
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_tvalid", mac_axis_tvalid, 0);
      chk("rst_tlast", mac_axis_tlast, 0);
      chk("rst_tdata", mac_axis_tdata, 0);
      chk("rst_treadys", {arp_axis_tready, ip_axis_tready}, 0);
      chk("rst_busy", busy, 0);
      chk("rst_grant", grant, 0);
      @(posedge clk);
      #1;
      aresetn = 1'b1;
      model_last_ip = 1'b1;

      // ARP broadcast, 28-byte payload
      arp_dst_mac = 48'hFFFF_FFFF_FFFF;
      add_frame(1'b0, 28);
      build_expected();
      drive();
      req_cyc = cyc;
      check_stream("arp28");
      if (cap.size() > 13) begin
         chk("arp28_latency", cap_cyc[0] - req_cyc, 1);
         chk("arp28_dst0", cap[0], 9'h0FF);
         chk("arp28_src0", cap[6], 9'h001);
         chk("arp28_src5", cap[11], 9'h006);
         chk("arp28_type", {cap[12], cap[13]}, {9'h008, 9'h006});
      end
      chk("arp28_total", cap.size(), PAD ? 60 : 42);

      // Simultaneous requests right after reset, 46-byte payloads
      do_reset();
      arp_dst_mac = {16'h0, 32'($urandom)};
      ip_dst_mac = {32'($urandom), 16'h1234};
      add_frame(1'b0, 46);
      add_frame(1'b1, 46);
      build_expected();
      drive();
      check_stream("tie");
      if (cap.size() > 60) begin
         chk("tie_first_grant", gq[0], 2'b01);
         chk("tie_spacing", cap_cyc[60] - cap_cyc[59], 2);
      end

      // Three frames per port queued back-to-back
      clear_all();
      for (int i = 0; i < 3; i++) begin
         add_frame(1'b0, $urandom_range(30, 70));
         add_frame(1'b1, $urandom_range(30, 70));
      end
      build_expected();
      check_stream("alt");

      // MAC ready toggling 1,0
      clear_all();
      rdy_mode = 1;
      add_frame(1'b0, 28);
      add_frame(1'b1, 50);
      build_expected();
      check_stream("toggle");
      chk("toggle_stable", stall_err, 0);

      // Random ready, random lengths
      clear_all();
      rdy_mode = 2;
      for (int i = 0; i < 3; i++) add_frame(1'b0, $urandom_range(1, 80));
      for (int i = 0; i < 2; i++) add_frame(1'b1, $urandom_range(1, 80));
      build_expected();
      check_stream("rand");
      chk("rand_stable", stall_err, 0);

      // Maximum-size IPv4 frame
      clear_all();
      rdy_mode = 0;
      add_frame(1'b1, 1500);
      build_expected();
      check_stream("jumbo");
      chk("jumbo_total", cap.size(), 1514);

      // Reset while IPv4 payload byte 5 is on the bus
      clear_all();
      add_frame(1'b1, 40);
      for (int k = 0; k < 200 && cap.size() < 19; k++) cycle();
      chk("rst_mid_reached", cap.size(), 19);
      aresetn = 1'b0;
      @(negedge clk);
      @(posedge clk);
      #1;
      clear_all();
      drive();
      @(negedge clk);
      chk("rst_mid_tvalid", mac_axis_tvalid, 0);
      chk("rst_mid_busy", busy, 0);
      chk("rst_mid_grant", grant, 0);
      chk("rst_mid_tready", ip_axis_tready, 0);
      @(posedge clk);
      #1;
      aresetn = 1'b1;
      model_last_ip = 1'b1;
      add_frame(1'b0, 20);
      build_expected();
      drive();
      check_stream("post_rst");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
